// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between execute stage and a word-wide, registered-read data memory.
// Ports: req_* request handshake, resp_* completion pulse, mem_* word memory side.
module lsu_mem_ctrl #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

   state_t      state, state_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic        fault_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        f3_ok;
   logic        misal;
   logic        fault_in;
   logic        is_sw;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept = req_valid && (state == IDLE);
   assign is_sw  = req_we && (req_funct3 == 3'b010);

   // Checks are evaluated on the raw request at the acceptance edge.
   always_comb begin
      f3_ok = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = !req_we;
         default:                f3_ok = 1'b0;
      endcase
      misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      fault_in = !f3_ok || misal || (req_addr >= LIMIT);
   end

   // Lane extraction and sub-word merge against the word read back.
   always_comb begin
      byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext = mem_rdata;
      unique case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = mem_rdata;
      endcase
      merged = mem_rdata;
      if (f3_q[1:0] == 2'b00)
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // mem_we is decoded from state so an asynchronous reset removes it at once.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
      mem_we     = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               if (fault_in)   state_nx = RESP;
               else if (is_sw) state_nx = WR;
               else            state_nx = RD;
            end
         end
         RD:   state_nx = DATA;
         DATA: state_nx = we_q ? WR : RESP;
         WR: begin
            mem_we   = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_fault = fault_q;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         lane_q      <= 2'd0;
         wdata_q     <= 32'd0;
         fault_q     <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            fault_q <= fault_in;
            if (fault_in)
               rdata_q <= 32'd0;
            else
               mem_addr_q <= {2'b00, req_addr[31:2]};
            if (!fault_in && is_sw)
               mem_wdata_q <= req_wdata;
         end
         if (state == DATA) begin
            if (we_q) mem_wdata_q <= merged;
            else      rdata_q     <= load_ext;
         end
         if (state == WR)
            rdata_q <= 32'd0;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_rdata = rdata_q;

endmodule
